csr_unit: RTL and testbench

Parametrised machine-mode CSR file that replaces the fixed-register CSR block in the 5-stage core. Reads are addressed from ID and returned registered to EX. Writes, trap entry and mret are applied from WB. Adds set/clear read-modify-write ops, mstatus with MIE/MPIE, mcountinhibit, configurable-width counters, NUM_HPM event counters, vectored mtvec, illegal-access flagging and mhartid.

---
 rtl/csr_unit_if.sv | 30 +++
 rtl/csr_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_csr_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_unit_if.sv
// Trap descriptor type and the ID-read / WB-write CSR access bus.
// The master is the pipeline side; the slave is the CSR file.
package csr_unit_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_interrupt;
    logic [30:0] mcause;
    logic [31:0] pc;
  } trap_info_t;
endpackage

interface csr_unit_if;
  logic [11:0] id_csr_raddr_i;
  logic [31:0] ex_csr_rdata_q;
  logic        ex_csr_illegal_q;
  logic [1:0]  wb_csr_op_i;
  logic [11:0] wb_csr_waddr_i;
  logic [31:0] wb_csr_wdata_i;
  logic        wb_csr_illegal_o;

  modport master (
    output id_csr_raddr_i, wb_csr_op_i, wb_csr_waddr_i, wb_csr_wdata_i,
    input  ex_csr_rdata_q, ex_csr_illegal_q, wb_csr_illegal_o
  );

  modport slave (
    input  id_csr_raddr_i, wb_csr_op_i, wb_csr_waddr_i, wb_csr_wdata_i,
    output ex_csr_rdata_q, ex_csr_illegal_q, wb_csr_illegal_o
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file: registered reads from ID, writes/trap/mret from WB,
// configurable-width cycle/instret/HPM counters and vectored trap target.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int unsigned NUM_HPM       = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter logic [31:0] HART_ID       = 32'd0,
  parameter bit          VECTORED_EN   = 1'b1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  csr_unit_if.slave                                bus,
  input  logic                                     ex_valid_i,
  input  logic                                     mem_valid_i,
  input  logic                                     wb_valid_i,
  input  trap_info_t                               wb_trap_i,
  input  logic [31:0]                              wb_trap_tval_i,
  input  logic                                     wb_mret_i,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
  output logic [31:0]                              trap_handler_addr_q,
  output logic [31:0]                              mepc_o,
  output logic                                     irq_enable_o
);

  localparam int unsigned NH = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int unsigned HW = COUNTER_WIDTH - 32;
  localparam logic [63:0] InhFull = (64'd1 << (NUM_HPM + 3)) - 64'd1;
  localparam logic [31:0] InhMask = InhFull[31:0] & 32'hFFFF_FFFD;

  logic                     r_mie, r_mpie;
  logic [31:0]              r_mtvec, r_inh, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [COUNTER_WIDTH-1:0] r_mcycle, r_minstret;
  logic [COUNTER_WIDTH-1:0] r_hpm [NH];
  logic [31:0]              r_rdata, r_handler;
  logic                     r_rd_ill;

  logic                     w_mie_nxt, w_mpie_nxt;
  logic [31:0]              w_mtvec_nxt, w_inh_nxt, w_mscratch_nxt, w_mepc_nxt;
  logic [31:0]              w_mcause_nxt, w_mtval_nxt, w_handler_nxt;
  logic [COUNTER_WIDTH-1:0] w_mcycle_nxt, w_minstret_nxt;
  logic [COUNTER_WIDTH-1:0] w_hpm_nxt [NH];

  logic [31:0] w_fwd_sum, w_rd_val, w_wr_old, w_new, w_base;
  logic        w_rd_ok, w_wr_ok, w_illegal, w_trap, w_retire, w_wr_en;

  assign w_fwd_sum = 32'(ex_valid_i) + 32'(mem_valid_i) + 32'(wb_valid_i);

  // Shared address decode for the read port and the RMW source operand.
  function automatic void csr_decode(input logic [11:0] addr, input logic fwd,
                                     output logic [31:0] val, output logic ok);
    val = '0;
    ok  = 1'b1;
    case (addr)
      12'h300: val = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      12'h305: val = r_mtvec;
      12'h320: val = r_inh;
      12'h340: val = r_mscratch;
      12'h341: val = r_mepc;
      12'h342: val = r_mcause;
      12'h343: val = r_mtval;
      12'hB00: val = r_mcycle[31:0];
      12'hB80: val = 32'(r_mcycle[COUNTER_WIDTH-1:32]);
      12'hB02: val = (fwd && !r_inh[2]) ? r_minstret[31:0] + w_fwd_sum : r_minstret[31:0];
      12'hB82: val = 32'(r_minstret[COUNTER_WIDTH-1:32]);
      12'hF14: val = HART_ID;
      default: begin
        ok = 1'b0;
        for (int i = 0; i < int'(NUM_HPM); i++) begin
          if (addr == 12'hB03 + 12'(i)) begin
            val = r_hpm[i][31:0];
            ok  = 1'b1;
          end else if (addr == 12'hB83 + 12'(i)) begin
            val = 32'(r_hpm[i][COUNTER_WIDTH-1:32]);
            ok  = 1'b1;
          end
        end
      end
    endcase
  endfunction

  // A half write suppresses that half's own increment and any carry across.
  function automatic logic [COUNTER_WIDTH-1:0] cnt_upd(input logic [COUNTER_WIDTH-1:0] cur,
                                                      input logic inc, input logic wr_lo,
                                                      input logic wr_hi,
                                                      input logic [31:0] wval);
    logic [COUNTER_WIDTH-1:0] res;
    logic [31:0]              lo_inc;
    lo_inc = cur[31:0] + 32'(inc);
    res    = cur + COUNTER_WIDTH'(inc);
    if (wr_lo) begin
      res = {cur[COUNTER_WIDTH-1:32], wval};
    end else if (wr_hi) begin
      res = {wval[HW-1:0], lo_inc};
    end
    return res;
  endfunction

  always_comb begin
    csr_decode(bus.id_csr_raddr_i, 1'b1, w_rd_val, w_rd_ok);
  end

  always_comb begin
    csr_decode(bus.wb_csr_waddr_i, 1'b0, w_wr_old, w_wr_ok);
  end

  assign w_illegal = (bus.wb_csr_op_i != 2'd0) && (!w_wr_ok || bus.wb_csr_waddr_i == 12'hF14);
  assign w_trap    = wb_valid_i && wb_trap_i.valid;
  assign w_retire  = wb_valid_i && !wb_trap_i.valid;
  assign w_wr_en   = w_retire && !wb_mret_i && (bus.wb_csr_op_i != 2'd0) && !w_illegal;

  always_comb begin
    w_new = w_wr_old;
    case (bus.wb_csr_op_i)
      2'd1:    w_new = bus.wb_csr_wdata_i;
      2'd2:    w_new = w_wr_old | bus.wb_csr_wdata_i;
      2'd3:    w_new = w_wr_old & ~bus.wb_csr_wdata_i;
      default: w_new = w_wr_old;
    endcase
  end

  always_comb begin
    w_mie_nxt      = r_mie;
    w_mpie_nxt     = r_mpie;
    w_mtvec_nxt    = r_mtvec;
    w_inh_nxt      = r_inh;
    w_mscratch_nxt = r_mscratch;
    w_mepc_nxt     = r_mepc;
    w_mcause_nxt   = r_mcause;
    w_mtval_nxt    = r_mtval;
    if (w_trap) begin
      w_mepc_nxt   = wb_trap_i.pc;
      w_mcause_nxt = {wb_trap_i.is_interrupt, wb_trap_i.mcause};
      w_mtval_nxt  = wb_trap_tval_i;
      w_mpie_nxt   = r_mie;
      w_mie_nxt    = 1'b0;
    end else if (wb_mret_i) begin
      w_mie_nxt  = r_mpie;
      w_mpie_nxt = 1'b1;
    end else if (w_wr_en) begin
      case (bus.wb_csr_waddr_i)
        12'h300: begin
          w_mie_nxt  = w_new[3];
          w_mpie_nxt = w_new[7];
        end
        12'h305: w_mtvec_nxt    = {w_new[31:2], 1'b0, w_new[0] & VECTORED_EN};
        12'h320: w_inh_nxt      = w_new & InhMask;
        12'h340: w_mscratch_nxt = w_new;
        12'h341: w_mepc_nxt     = {w_new[31:2], 2'b00};
        12'h342: w_mcause_nxt   = w_new;
        12'h343: w_mtval_nxt    = w_new;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mcycle_nxt = cnt_upd(r_mcycle, !r_inh[0],
                           w_wr_en && bus.wb_csr_waddr_i == 12'hB00,
                           w_wr_en && bus.wb_csr_waddr_i == 12'hB80, w_new);
    w_minstret_nxt = cnt_upd(r_minstret, w_retire && !r_inh[2],
                             w_wr_en && bus.wb_csr_waddr_i == 12'hB02,
                             w_wr_en && bus.wb_csr_waddr_i == 12'hB82, w_new);
    for (int i = 0; i < int'(NH); i++) begin
      w_hpm_nxt[i] = r_hpm[i];
    end
    for (int i = 0; i < int'(NUM_HPM); i++) begin
      w_hpm_nxt[i] = cnt_upd(r_hpm[i], hpm_event_i[i] && !r_inh[3+i],
                             w_wr_en && bus.wb_csr_waddr_i == 12'hB03 + 12'(i),
                             w_wr_en && bus.wb_csr_waddr_i == 12'hB83 + 12'(i), w_new);
    end
  end

  // Vectored entry applies only to interrupts; exceptions use the base.
  assign w_base = {r_mtvec[31:2], 2'b00};
  always_comb begin
    w_handler_nxt = w_base;
    if (r_mtvec[0] && r_mcause[31]) begin
      w_handler_nxt = w_base + {r_mcause[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= '0;
      r_inh      <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
      for (int i = 0; i < int'(NH); i++) begin
        r_hpm[i] <= '0;
      end
      r_rdata    <= '0;
      r_rd_ill   <= 1'b0;
      r_handler  <= '0;
    end else begin
      r_mie      <= w_mie_nxt;
      r_mpie     <= w_mpie_nxt;
      r_mtvec    <= w_mtvec_nxt;
      r_inh      <= w_inh_nxt;
      r_mscratch <= w_mscratch_nxt;
      r_mepc     <= w_mepc_nxt;
      r_mcause   <= w_mcause_nxt;
      r_mtval    <= w_mtval_nxt;
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
      for (int i = 0; i < int'(NH); i++) begin
        r_hpm[i] <= w_hpm_nxt[i];
      end
      r_rdata    <= w_rd_val;
      r_rd_ill   <= !w_rd_ok;
      r_handler  <= w_handler_nxt;
    end
  end

  assign bus.ex_csr_rdata_q   = r_rdata;
  assign bus.ex_csr_illegal_q = r_rd_ill;
  assign bus.wb_csr_illegal_o = w_illegal;
  assign trap_handler_addr_q  = r_handler;
  assign mepc_o               = r_mepc;
  assign irq_enable_o         = r_mie;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed vector table, corner-case sequences
// and randomized traffic against a behavioural CSR model.
module tb_csr_unit;
  import csr_unit_pkg::*;

  localparam int unsigned NHPM = 4;
  localparam logic [31:0] HART = 32'h0000_0005;
  localparam longint unsigned CMOD = 64'd1 << 34;

  logic        clk_i, rst_ni;
  logic        ex_v, mem_v, wb_v, mret;
  trap_info_t  trap;
  logic [31:0] tval, handler, mepc;
  logic        irq;
  logic [NHPM-1:0] hpm_ev;

  csr_unit_if bus ();

  csr_unit #(
    .NUM_HPM      (NHPM),
    .COUNTER_WIDTH(34),
    .HART_ID      (HART),
    .VECTORED_EN  (1'b1)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .bus                (bus),
    .ex_valid_i         (ex_v),
    .mem_valid_i        (mem_v),
    .wb_valid_i         (wb_v),
    .wb_trap_i          (trap),
    .wb_trap_tval_i     (tval),
    .wb_mret_i          (mret),
    .hpm_event_i        (hpm_ev),
    .trap_handler_addr_q(handler),
    .mepc_o             (mepc),
    .irq_enable_o       (irq)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic s_wbill;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model state
  bit              m_mie, m_mpie;
  logic [31:0]     m_mtvec, m_inh, m_scratch, m_mepc, m_mcause, m_mtval, m_handler;
  longint unsigned m_cnt [7];

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = 0; m_inh = 0; m_scratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_handler = 0;
    for (int k = 0; k < 7; k++) m_cnt[k] = 0;
  endfunction

  function automatic void m_read(input logic [11:0] a, input bit fwd,
                                 output logic [31:0] v, output bit ok);
    logic [11:0] b;
    int k;
    v = 0;
    ok = 1;
    b = a & 12'hF7F;
    if (a == 12'h300) v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
    else if (a == 12'h305) v = m_mtvec;
    else if (a == 12'h320) v = m_inh;
    else if (a == 12'h340) v = m_scratch;
    else if (a == 12'h341) v = m_mepc;
    else if (a == 12'h342) v = m_mcause;
    else if (a == 12'h343) v = m_mtval;
    else if (a == 12'hF14) v = HART;
    else if (b >= 12'hB00 && b <= 12'hB00 + 12'(2 + NHPM) && b != 12'hB01) begin
      k = int'(b - 12'hB00);
      if (a[7]) v = 32'(m_cnt[k] >> 32);
      else begin
        v = m_cnt[k][31:0];
        if (k == 2 && fwd && !m_inh[2]) v = v + 32'(ex_v) + 32'(mem_v) + 32'(wb_v);
      end
    end else ok = 0;
  endfunction

  function automatic bit m_wb_illegal();
    logic [31:0] v;
    bit ok;
    m_read(bus.wb_csr_waddr_i, 0, v, ok);
    return (bus.wb_csr_op_i != 0) && (!ok || bus.wb_csr_waddr_i == 12'hF14);
  endfunction

  function automatic void m_step();
    bit tr, retire, commit, ok;
    logic [31:0] old, nw;
    logic [11:0] wa;
    longint unsigned inc, base;
    base = longint'(m_mtvec & 32'hFFFF_FFFC);
    if (m_mtvec[0] && m_mcause[31]) base = base + 4 * longint'(m_mcause & 32'h7FFF_FFFF);
    m_handler = 32'(base);
    tr     = wb_v && trap.valid;
    retire = wb_v && !trap.valid;
    wa     = bus.wb_csr_waddr_i;
    commit = retire && !mret && bus.wb_csr_op_i != 0 && !m_wb_illegal();
    m_read(wa, 0, old, ok);
    case (bus.wb_csr_op_i)
      2'd1:    nw = bus.wb_csr_wdata_i;
      2'd2:    nw = old | bus.wb_csr_wdata_i;
      2'd3:    nw = old & ~bus.wb_csr_wdata_i;
      default: nw = old;
    endcase
    // Inhibit bit k governs the counter living at 0xB00+k.
    for (int k = 0; k <= 2 + int'(NHPM); k++) begin
      if (k == 1) continue;
      if (k == 0) inc = 1;
      else if (k == 2) inc = longint'(retire);
      else inc = longint'(hpm_ev[k-3]);
      if (m_inh[k]) inc = 0;
      if (commit && wa == 12'hB00 + 12'(k))
        m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | longint'(nw);
      else if (commit && wa == 12'hB80 + 12'(k))
        m_cnt[k] = ((longint'(nw) % 4) << 32) | ((m_cnt[k] + inc) & 64'hFFFF_FFFF);
      else
        m_cnt[k] = (m_cnt[k] + inc) % CMOD;
    end
    if (tr) begin
      m_mepc = trap.pc;
      m_mcause = {trap.is_interrupt, trap.mcause};
      m_mtval = tval;
      m_mpie = m_mie;
      m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (commit) begin
      case (wa)
        12'h300: begin m_mie = nw[3]; m_mpie = nw[7]; end
        12'h305: m_mtvec = nw & 32'hFFFF_FFFD;
        12'h320: m_inh = nw & 32'h0000_007D;
        12'h340: m_scratch = nw;
        12'h341: m_mepc = nw & 32'hFFFF_FFFC;
        12'h342: m_mcause = nw;
        12'h343: m_mtval = nw;
        default: ;
      endcase
    end
  endfunction

  task automatic tick();
    logic [31:0] e_rd;
    bit e_ok;
    #1;
    s_wbill = bus.wb_csr_illegal_o;
    chk("wb_illegal", 64'(s_wbill), 64'(m_wb_illegal()));
    m_read(bus.id_csr_raddr_i, 1, e_rd, e_ok);
    m_step();
    @(posedge clk_i);
    #1;
    chk("rdata", 64'(bus.ex_csr_rdata_q), 64'(e_rd));
    chk("rd_illegal", 64'(bus.ex_csr_illegal_q), 64'(!e_ok));
    chk("irq_enable", 64'(irq), 64'(m_mie));
    chk("mepc", 64'(mepc), 64'(m_mepc));
    chk("handler", 64'(handler), 64'(m_handler));
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] wa, input logic [31:0] wd,
                     input logic [11:0] ra);
    bus.wb_csr_op_i = op;
    bus.wb_csr_waddr_i = wa;
    bus.wb_csr_wdata_i = wd;
    bus.id_csr_raddr_i = ra;
    tick();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_rdata"}, 64'(bus.ex_csr_rdata_q), 64'd0);
    chk({nm, "_rdill"}, 64'(bus.ex_csr_illegal_q), 64'd0);
    chk({nm, "_handler"}, 64'(handler), 64'd0);
    chk({nm, "_mepc"}, 64'(mepc), 64'd0);
    chk({nm, "_irq"}, 64'(irq), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_rill;
    logic        exp_wbill;
  } vec_t;

  vec_t tbl [16];
  logic [11:0] pool [20];

  initial begin
    tbl[0]  = '{2'd0, 12'h000, 32'h0000_0000, 12'h300, 32'h0000_1800, 1'b0, 1'b0};
    tbl[1]  = '{2'd0, 12'h000, 32'h0000_0000, 12'h7C0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{2'd1, 12'h340, 32'hA5A5_0000, 12'h340, 32'h0000_0000, 1'b0, 1'b0};
    tbl[3]  = '{2'd2, 12'h340, 32'h0000_00FF, 12'h340, 32'hA5A5_0000, 1'b0, 1'b0};
    tbl[4]  = '{2'd3, 12'h340, 32'hA000_0000, 12'h340, 32'hA5A5_00FF, 1'b0, 1'b0};
    tbl[5]  = '{2'd0, 12'h000, 32'h0000_0000, 12'h340, 32'h05A5_00FF, 1'b0, 1'b0};
    tbl[6]  = '{2'd1, 12'hF14, 32'h0000_1234, 12'hF14, HART,          1'b0, 1'b1};
    tbl[7]  = '{2'd0, 12'h000, 32'h0000_0000, 12'hF14, HART,          1'b0, 1'b0};
    tbl[8]  = '{2'd1, 12'h305, 32'h0000_1003, 12'h305, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 12'h000, 32'h0000_0000, 12'h305, 32'h0000_1001, 1'b0, 1'b0};
    tbl[10] = '{2'd1, 12'h341, 32'h0000_1237, 12'h341, 32'h0000_0000, 1'b0, 1'b0};
    tbl[11] = '{2'd0, 12'h000, 32'h0000_0000, 12'h341, 32'h0000_1234, 1'b0, 1'b0};
    tbl[12] = '{2'd1, 12'hB07, 32'h0000_FFFF, 12'hB07, 32'h0000_0000, 1'b1, 1'b1};
    tbl[13] = '{2'd1, 12'h320, 32'hFFFF_FFFF, 12'h320, 32'h0000_0000, 1'b0, 1'b0};
    tbl[14] = '{2'd1, 12'h320, 32'h0000_0000, 12'h320, 32'h0000_007D, 1'b0, 1'b0};
    tbl[15] = '{2'd3, 12'h7C0, 32'h0000_0001, 12'h320, 32'h0000_0000, 1'b0, 1'b1};
    pool = '{12'h300, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
             12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB06, 12'hB83, 12'hB86, 12'hB07,
             12'hB87, 12'hF14, 12'h7C0, 12'h301};

    rst_ni = 1'b0;
    ex_v = 0; mem_v = 0; wb_v = 0; mret = 0; hpm_ev = '0;
    trap = '0; tval = '0;
    bus.wb_csr_op_i = 0; bus.wb_csr_waddr_i = 0; bus.wb_csr_wdata_i = 0;
    bus.id_csr_raddr_i = 0;
    m_reset();
    #2;
    chk_reset_outputs("reset");
    #5 rst_ni = 1'b1;

    wb_v = 1;
    for (int i = 0; i < 16; i++) begin
      acc(tbl[i].op, tbl[i].waddr, tbl[i].wdata, tbl[i].raddr);
      chk($sformatf("tbl%0d_rd", i), 64'(bus.ex_csr_rdata_q), 64'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_rill", i), 64'(bus.ex_csr_illegal_q), 64'(tbl[i].exp_rill));
      chk($sformatf("tbl%0d_wbill", i), 64'(s_wbill), 64'(tbl[i].exp_wbill));
    end

    // Trap / mret sequencing with vectored mtvec = 0x1001
    acc(2'd1, 12'h300, 32'h0000_0008, 12'h300);
    chk("mie_set", 64'(irq), 64'd1);
    trap = '{valid: 1'b1, is_interrupt: 1'b1, mcause: 31'd7, pc: 32'h8000_0104};
    tval = 32'hDEAD_BEEF;
    acc(2'd0, 12'h000, 32'h0, 12'h300);
    trap = '0;
    chk("trap_mie", 64'(irq), 64'd0);
    chk("trap_mepc", 64'(mepc), 64'h8000_0104);
    acc(2'd0, 12'h000, 32'h0, 12'h300);
    chk("mstatus_trap", 64'(bus.ex_csr_rdata_q), 64'h1880);
    chk("vec_handler", 64'(handler), 64'h101C);
    mret = 1;
    acc(2'd0, 12'h000, 32'h0, 12'h300);
    mret = 0;
    chk("mret_mie", 64'(irq), 64'd1);
    acc(2'd0, 12'h000, 32'h0, 12'h300);
    chk("mstatus_mret", 64'(bus.ex_csr_rdata_q), 64'h1888);
    trap = '{valid: 1'b1, is_interrupt: 1'b0, mcause: 31'd7, pc: 32'h8000_0200};
    mret = 1;
    acc(2'd0, 12'h000, 32'h0, 12'h300);
    trap = '0;
    mret = 0;
    acc(2'd0, 12'h000, 32'h0, 12'h300);
    chk("mstatus_trap_mret", 64'(bus.ex_csr_rdata_q), 64'h1880);
    chk("exc_handler", 64'(handler), 64'h1000);
    chk("trap_mret_mepc", 64'(mepc), 64'h8000_0200);

    // mcycle carry into high half, wrap at 2^34, inhibit freeze
    acc(2'd1, 12'hB80, 32'h0, 12'h000);
    acc(2'd1, 12'hB00, 32'hFFFF_FFFE, 12'h000);
    acc(2'd0, 12'h000, 32'h0, 12'hB80);
    acc(2'd0, 12'h000, 32'h0, 12'hB80);
    acc(2'd0, 12'h000, 32'h0, 12'hB80);
    chk("mcycle_carry", 64'(bus.ex_csr_rdata_q), 64'd1);
    acc(2'd1, 12'hB80, 32'hFFFF_FFFF, 12'h000);
    acc(2'd1, 12'hB00, 32'hFFFF_FFFF, 12'h000);
    acc(2'd0, 12'h000, 32'h0, 12'hB80);
    chk("mcycle_max_hi", 64'(bus.ex_csr_rdata_q), 64'd3);
    acc(2'd0, 12'h000, 32'h0, 12'hB80);
    chk("mcycle_wrap_hi", 64'(bus.ex_csr_rdata_q), 64'd0);
    acc(2'd0, 12'h000, 32'h0, 12'hB00);
    chk("mcycle_wrap_lo", 64'(bus.ex_csr_rdata_q), 64'd1);
    acc(2'd2, 12'h320, 32'h1, 12'h000);
    acc(2'd1, 12'hB00, 32'h100, 12'h000);
    acc(2'd0, 12'h000, 32'h0, 12'hB00);
    chk("mcycle_frozen0", 64'(bus.ex_csr_rdata_q), 64'h100);
    acc(2'd0, 12'h000, 32'h0, 12'hB00);
    chk("mcycle_frozen1", 64'(bus.ex_csr_rdata_q), 64'h100);
    acc(2'd3, 12'h320, 32'h1, 12'h000);

    // minstret in-flight forwarding
    acc(2'd2, 12'h320, 32'h4, 12'h000);
    acc(2'd1, 12'hB82, 32'h0, 12'h000);
    acc(2'd1, 12'hB02, 32'd10, 12'h000);
    acc(2'd3, 12'h320, 32'h4, 12'h000);
    ex_v = 1; mem_v = 1;
    acc(2'd0, 12'h000, 32'h0, 12'hB02);
    chk("minstret_fwd", 64'(bus.ex_csr_rdata_q), 64'd13);
    acc(2'd2, 12'h320, 32'h4, 12'h000);
    acc(2'd0, 12'h000, 32'h0, 12'hB02);
    chk("minstret_inh", 64'(bus.ex_csr_rdata_q), 64'd12);
    acc(2'd3, 12'h320, 32'h4, 12'h000);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ex_v = 1'($urandom); mem_v = 1'($urandom); wb_v = 1'($urandom);
      hpm_ev = 4'($urandom);
      mret = ($urandom_range(0, 15) == 0);
      trap.valid = ($urandom_range(0, 15) == 0);
      trap.is_interrupt = 1'($urandom);
      trap.mcause = 31'($urandom);
      trap.pc = $urandom;
      tval = $urandom;
      acc($urandom_range(0, 1) == 0 ? 2'd0 : 2'($urandom_range(1, 3)),
          pool[$urandom_range(0, 19)], $urandom, pool[$urandom_range(0, 19)]);
    end

    // Asynchronous reset mid-run discards state without a clock edge
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m_reset();
    #3 rst_ni = 1'b1;
    trap = '0; mret = 0;
    for (int n = 0; n < 200; n++) begin
      ex_v = 1'($urandom); mem_v = 1'($urandom); wb_v = 1'($urandom);
      hpm_ev = 4'($urandom);
      acc(2'($urandom), pool[$urandom_range(0, 19)], $urandom, pool[$urandom_range(0, 19)]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
